pm_spm_ctrl: RTL
================

Name: pm_spm_ctrl

Overview:
- Sequencer and port arbiter for the single-port, CPU-writable AVR program memory (BRAM, registered address, one write port).
- Shares the PM port between CPU instruction fetch and a self-timed SPM engine.
- The SPM engine implements an AVR-style temporary page buffer plus page erase, page write and buffer clear, stalling the CPU while it owns the port.
- Sits between the CPU fetch/SPM interface and the PM instance. The PM clock edge is the PM's own concern; this block is rising-edge only.

Parameters:
- WORD_SIZE, 16, PM word width.
- ADDR_W, 13, PM word-address width.
- PAGE_W, 6, log2 of page size in words (64 words per page); must be < ADDR_W.

Ports:
- clk_i, in, 1, system clock; all state updates on the rising edge.
- rst_i, in, 1, reset, asynchronous, active-high.
- cpu_addr_i, in, ADDR_W, CPU fetch word address.
- cpu_stall_o, out, 1, CPU must hold its fetch and PC while high.
- spm_req_i, in, 1, SPM command strobe, sampled only in IDLE.
- spm_op_i, in, 2, command: 00 fill buffer, 01 page erase, 10 page write, 11 buffer clear.
- spm_addr_i, in, ADDR_W, word address; low PAGE_W bits select the buffer slot, high bits select the page.
- spm_data_i, in, WORD_SIZE, fill data.
- spm_busy_o, out, 1, high whenever not in IDLE.
- spm_done_o, out, 1, one-cycle pulse on command completion.
- pm_addr_o, out, ADDR_W, to PM addr_i.
- pm_we_o, out, 1, to PM we_i.
- pm_data_o, out, WORD_SIZE, to PM data_i.

Behaviour:
- States: IDLE, FILL, ERASE, WRITE, CLEAR, RECOVER. Reset enters IDLE with cnt=0, page base 0, and every buffer word set to all ones. Outputs in reset: cpu_stall_o=0, spm_busy_o=0, spm_done_o=0, pm_we_o=0.
- In IDLE, pm_addr_o = cpu_addr_i combinationally, pm_we_o=0, and pm_data_o = all ones (don't-care).
- IDLE with spm_req_i high: latch base = spm_addr_i[ADDR_W-1:PAGE_W], latch slot/data, and go to the state selected by op. In IDLE, spm_req_i low keeps the block in IDLE.
- FILL, 1 cycle:
  - buf[slot] <= latched data; PM is untouched and the CPU is not stalled.
  - done pulses in this cycle, then the block returns to IDLE.
  - Total latency: request at cycle N gives done at N+1.
  - A fill to an already-written slot overwrites it (no AND-merge).
- CLEAR, 1 cycle: every buf word is set to all ones; done pulses; the block returns to IDLE. The CPU is not stalled.
- ERASE, 2^PAGE_W cycles:
  - pm_we_o=1, pm_addr_o = {base, cnt}, pm_data_o = all ones.
  - cnt goes 0 to 2^PAGE_W-1; on the last word, cnt wraps to 0 and the block goes to RECOVER.
- WRITE: same timing as ERASE, but pm_data_o = buf[cnt] (combinational read). On the transition to RECOVER, the whole buffer is set to all ones (auto-clear).
- RECOVER, 1 cycle:
  - pm_we_o=0, pm_addr_o = cpu_addr_i so the PM re-registers the fetch address.
  - cpu_stall_o stays high; done pulses; the block returns to IDLE.
- cpu_stall_o = 1 in ERASE, WRITE and RECOVER, else 0. It is registered (state-decoded) and never depends combinationally on spm_req_i.
- Erase/write latency: request at cycle N, writes at N+1 through N+2^PAGE_W, RECOVER/done at N+2^PAGE_W+1, stall low from N+2^PAGE_W+2.
- spm_busy_o = (state != IDLE). spm_req_i outside IDLE is ignored; it is not queued.
- Erase and write ignore the slot bits; the page is always aligned. Erase does not touch the buffer.
- Reset mid-operation returns to IDLE immediately. The PM page is left partially written (the words already written stay). The buffer becomes all ones. No done pulse is generated.
- Page-write data is not AND-merged with existing PM contents; software must erase first.

Decomposition:
- Shared package holds:
  - op encodings: SPM_OP_FILL=2'b00, SPM_OP_ERASE=2'b01, SPM_OP_WRITE=2'b10, SPM_OP_CLEAR=2'b11;
  - state encoding constants;
  - the erased-word constant (all ones).
- One sub-module: spm_page_buf.
  - Contents: 2^PAGE_W x WORD_SIZE flop array with async reset to all ones, one write port, a combinational read port, and a single-cycle clear_i.
- The FSM, counter and port mux stay in pm_spm_ctrl.

Test Plan:
- Reset, then idle: cpu_addr_i=0x0123 → pm_addr_o=0x0123, pm_we_o=0, cpu_stall_o=0, spm_busy_o=0.
- Fill slots 0..63 with data 0xA000+i at spm_addr 0x0040+i, then page write at spm_addr 0x0055:
  - expect 64 cycles of pm_we_o=1 with pm_addr_o 0x0040..0x007F and pm_data_o 0xA000..0xA03F;
  - stall high for 65 cycles, done at the RECOVER cycle;
  - PM model holds the data;
  - buffer reads back 0xFFFF afterwards.
- Page erase at spm_addr 0x1FC3: writes of 0xFFFF to 0x1FC0..0x1FFF only; neighbouring page 0x1F80 is unchanged; busy for 65 cycles.
- spm_req_i held high with op=erase during a write in progress: ignored. Exactly one done pulse, and the page holds the write data, not 0xFFFF.
- Fill slot 5 = 0x1234, then CLEAR, then write page 0: PM[5]=0xFFFF. Fill and clear produce done one cycle after the request with no stall.
- Assert rst_i at write cycle 10 (page 0x0040, data 0xA000+i):
  - PM words 0x0040..0x0049 are written with 0xA000..0xA009; the rest of the page is unchanged;
  - state IDLE, stall low, no done pulse, buffer all ones.

Source files
------------

// File: rtl/pm_spm_ctrl_pkg.sv
// Shared definitions for the program-memory SPM sequencer.
// Holds SPM op codes, the FSM state encoding and the erased PM word value.
package pm_spm_ctrl_pkg;

    localparam logic [1:0] SPM_OP_FILL  = 2'b00;
    localparam logic [1:0] SPM_OP_ERASE = 2'b01;
    localparam logic [1:0] SPM_OP_WRITE = 2'b10;
    localparam logic [1:0] SPM_OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_ERASE   = 3'd2,
        ST_WRITE   = 3'd3,
        ST_CLEAR   = 3'd4,
        ST_RECOVER = 3'd5
    } spm_state_e;

    // Erased flash/PM word; modules slice the low WORD_SIZE bits.
    localparam logic [63:0] PM_ERASED = '1;

endpackage

// File: rtl/pm_spm_ctrl_page_buf.sv
// Temporary SPM page buffer: 2^PAGE_W words, async reset to erased value.
// Ports: we_i/waddr_i/wdata_i write, raddr_i/rdata_o comb read, clear_i.
module spm_page_buf
    import pm_spm_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int PAGE_W    = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic [PAGE_W-1:0]    waddr_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    input  logic                 clear_i,
    input  logic [PAGE_W-1:0]    raddr_i,
    output logic [WORD_SIZE-1:0] rdata_o
);

    localparam int DEPTH = 1 << PAGE_W;
    localparam logic [WORD_SIZE-1:0] ERASED = PM_ERASED[WORD_SIZE-1:0];

    logic [WORD_SIZE-1:0] r_mem [DEPTH];

    // Clear wins over a same-cycle write; the FSM never issues both.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= ERASED;
        end else if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= ERASED;
        end else if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/pm_spm_ctrl.sv
// SPM sequencer and PM port arbiter between CPU fetch and page engine.
// Ports: clk_i/rst_i, cpu_* fetch side, spm_* command side, pm_* to BRAM.
module pm_spm_ctrl
    import pm_spm_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_W    = 13,
    parameter int PAGE_W    = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_W-1:0]    cpu_addr_i,
    output logic                 cpu_stall_o,
    input  logic                 spm_req_i,
    input  logic [1:0]           spm_op_i,
    input  logic [ADDR_W-1:0]    spm_addr_i,
    input  logic [WORD_SIZE-1:0] spm_data_i,
    output logic                 spm_busy_o,
    output logic                 spm_done_o,
    output logic [ADDR_W-1:0]    pm_addr_o,
    output logic                 pm_we_o,
    output logic [WORD_SIZE-1:0] pm_data_o
);

    localparam int BASE_W = ADDR_W - PAGE_W;
    localparam logic [WORD_SIZE-1:0] ERASED = PM_ERASED[WORD_SIZE-1:0];

    spm_state_e           r_state;
    logic [PAGE_W-1:0]    r_cnt;
    logic [BASE_W-1:0]    r_base;
    logic [PAGE_W-1:0]    r_slot;
    logic [WORD_SIZE-1:0] r_data;
    logic                 r_stall;
    logic                 r_done;

    logic                 w_last;
    logic                 w_buf_we;
    logic                 w_buf_clr;
    logic [WORD_SIZE-1:0] w_buf_rd;

    assign w_last    = (r_cnt == {PAGE_W{1'b1}});
    assign w_buf_we  = (r_state == ST_FILL);
    // Buffer auto-clears as the last page word is written.
    assign w_buf_clr = (r_state == ST_CLEAR) ||
                       ((r_state == ST_WRITE) && w_last);

    spm_page_buf #(
        .WORD_SIZE (WORD_SIZE),
        .PAGE_W    (PAGE_W)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (w_buf_we),
        .waddr_i (r_slot),
        .wdata_i (r_data),
        .clear_i (w_buf_clr),
        .raddr_i (r_cnt),
        .rdata_o (w_buf_rd)
    );

    // stall/done are registered from the next state so they never
    // depend combinationally on the request strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_base  <= '0;
            r_slot  <= '0;
            r_data  <= '0;
            r_stall <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done  <= 1'b0;
                    r_stall <= 1'b0;
                    if (spm_req_i) begin
                        r_base <= spm_addr_i[ADDR_W-1:PAGE_W];
                        r_slot <= spm_addr_i[PAGE_W-1:0];
                        r_data <= spm_data_i;
                        r_cnt  <= '0;
                        case (spm_op_i)
                            SPM_OP_FILL: begin
                                r_state <= ST_FILL;
                                r_done  <= 1'b1;
                            end
                            SPM_OP_ERASE: begin
                                r_state <= ST_ERASE;
                                r_stall <= 1'b1;
                            end
                            SPM_OP_WRITE: begin
                                r_state <= ST_WRITE;
                                r_stall <= 1'b1;
                            end
                            default: begin
                                r_state <= ST_CLEAR;
                                r_done  <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_FILL, ST_CLEAR: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                ST_ERASE, ST_WRITE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= ST_RECOVER;
                        r_done  <= 1'b1;
                    end
                end
                ST_RECOVER: begin
                    r_state <= ST_IDLE;
                    r_stall <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_stall <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // PM port mux: page engine owns the port only in ERASE/WRITE.
    always_comb begin
        pm_addr_o = cpu_addr_i;
        pm_we_o   = 1'b0;
        pm_data_o = ERASED;
        case (r_state)
            ST_ERASE: begin
                pm_addr_o = {r_base, r_cnt};
                pm_we_o   = 1'b1;
            end
            ST_WRITE: begin
                pm_addr_o = {r_base, r_cnt};
                pm_we_o   = 1'b1;
                pm_data_o = w_buf_rd;
            end
            default: ;
        endcase
    end

    assign cpu_stall_o = r_stall;
    assign spm_done_o  = r_done;
    assign spm_busy_o  = (r_state != ST_IDLE);

endmodule
